// File: rtl/flasher.sv
// I2C-controlled LED flasher. A small I2C slave exposes a MODE register
// that selects whether the red and green LEDs flash alternately or together.
module flasher #(
  parameter logic [7:0]  I2C_ADDR  = 8'h82,
  parameter int unsigned FLASH_DIV = 10_000_000
) (
  input  logic CLK,
  input  logic GSRn,
  inout  wire  SDA,
  inout  wire  SCL,
  output logic LEDR,
  output logic LEDG
);

  localparam int unsigned CW = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FLASH_DIV - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WR_BYTE  = 3'd3;
  localparam logic [2:0] ST_WR_ACK   = 3'd4;
  localparam logic [2:0] ST_RD_BYTE  = 3'd5;
  localparam logic [2:0] ST_RD_ACK   = 3'd6;

  logic [1:0]    scl_sync;
  logic [1:0]    sda_sync;
  logic          scl_prev;
  logic          sda_prev;
  logic [2:0]    warm;
  logic          scl_s;
  logic          sda_s;
  logic          edges_ok;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_cond;
  logic          stop_cond;

  logic [2:0]    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    tx;
  logic          sda_low;
  logic          wr_stb;
  logic [5:0]    ptr;
  logic [5:0]    mode;
  logic [5:0]    rd_data;
  logic [7:0]    tx_load;

  logic [CW-1:0] flash_cnt;
  logic          phase;

  // Open-drain bus: SDA is only ever pulled low, SCL is never driven.
  assign SDA = sda_low ? 1'b0 : 1'bz;
  assign SCL = 1'bz;

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
  // Edges are ignored until the pipeline holds real bus values, so a bus
  // caught mid-transfer at reset release cannot fake a START.
  assign edges_ok   = warm[2];
  assign scl_rise   = edges_ok & scl_s & ~scl_prev;
  assign scl_fall   = edges_ok & ~scl_s & scl_prev;
  assign start_cond = edges_ok & scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_cond  = edges_ok & scl_s & scl_prev & ~sda_prev & sda_s;

  assign rd_data = (ptr == 6'd2) ? mode : 6'd0;
  assign tx_load = {2'b01, rd_data};

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
      warm     <= 3'b000;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
      warm     <= {warm[1:0], 1'b1};
    end
  end

  // I2C slave FSM: bits sampled on SCL rise, SDA changed only after SCL fall.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      state   <= ST_IDLE;
      bit_cnt <= 4'd0;
      shift   <= 8'd0;
      tx      <= 8'd0;
      sda_low <= 1'b0;
      wr_stb  <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      if (start_cond) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        sda_low <= 1'b0;
      end else if (stop_cond) begin
        state   <= ST_IDLE;
        sda_low <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_WR_BYTE: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (state == ST_WR_BYTE && bit_cnt == 4'd7) wr_stb <= 1'b1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (state == ST_WR_BYTE) begin
                state   <= ST_WR_ACK;
                sda_low <= 1'b1;
              end else if (shift[7:1] == I2C_ADDR[7:1]) begin
                state   <= ST_ADDR_ACK;
                sda_low <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              // shift[0] still holds the R/W bit of the address byte.
              if (shift[0]) begin
                state   <= ST_RD_BYTE;
                tx      <= tx_load;
                sda_low <= ~tx_load[7];
              end else begin
                state   <= ST_WR_BYTE;
                sda_low <= 1'b0;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              state   <= ST_WR_BYTE;
              bit_cnt <= 4'd0;
              sda_low <= 1'b0;
            end
          end
          ST_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                state   <= ST_RD_ACK;
                sda_low <= 1'b0;
              end else begin
                tx      <= {tx[6:0], 1'b0};
                sda_low <= ~tx[6];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise && sda_s) begin
              state <= ST_IDLE;
            end else if (scl_fall) begin
              state   <= ST_RD_BYTE;
              tx      <= tx_load;
              sda_low <= ~tx_load[7];
              bit_cnt <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Register file: decode a completed write byte one cycle after its 8th bit.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      ptr  <= 6'd0;
      mode <= 6'd0;
    end else if (wr_stb) begin
      case (shift[7:6])
        2'b00:   ptr <= shift[5:0];
        2'b01:   if (ptr == 6'd2) mode <= shift[5:0];
        default: ;
      endcase
    end
  end

  // Flash timebase: phase toggles each time the counter wraps.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      flash_cnt <= '0;
      phase     <= 1'b0;
    end else if (flash_cnt == CNT_MAX) begin
      flash_cnt <= '0;
      phase     <= ~phase;
    end else begin
      flash_cnt <= flash_cnt + 1'b1;
    end
  end

  // Registered LED drive; MODE bit0 selects synchronous vs alternating.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      LEDR <= 1'b0;
      LEDG <= 1'b1;
    end else begin
      LEDR <= phase;
      LEDG <= mode[0] ? phase : ~phase;
    end
  end

endmodule

// File: tb/tb_flasher.sv
// Self-checking bench for flasher: bit-banged I2C master, directed scenarios
// and randomized transactions against a register/LED reference model.
module tb_flasher;

  localparam int unsigned DIV = 4;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic gsrn = 1'b0;
  logic m_sda = 1'b1;
  logic m_scl = 1'b1;
  logic ledr;
  logic ledg;
  wire  sda_bus;
  wire  scl_bus;

  int n_cmp = 0;
  int n_err = 0;
  int ncyc;

  logic [5:0] ptr_m;
  logic [5:0] mode_m;

  pullup (sda_bus);
  pullup (scl_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;
  assign scl_bus = m_scl ? 1'bz : 1'b0;

  flasher #(
    .I2C_ADDR (8'h82),
    .FLASH_DIV(DIV)
  ) dut (
    .CLK (clk),
    .GSRn(gsrn),
    .SDA (sda_bus),
    .SCL (scl_bus),
    .LEDR(ledr),
    .LEDG(ledg)
  );

  always #5 clk = ~clk;

  // Clock edges seen since the last reset release.
  always @(posedge clk or negedge gsrn) begin
    if (!gsrn) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the slave's register behaviour.
  task automatic model_reset();
    ptr_m  = 6'd0;
    mode_m = 6'd0;
  endtask

  task automatic model_write(input logic [7:0] v);
    if (v[7:6] == 2'b00) ptr_m = v[5:0];
    else if (v[7:6] == 2'b01 && ptr_m == 6'd2) mode_m = v[5:0];
  endtask

  function automatic logic [7:0] model_read();
    return 8'h40 | ((ptr_m == 6'd2) ? {2'b00, mode_m} : 8'h00);
  endfunction

  // I2C master primitives (quarter SCL period = Q clocks).
  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(2 * Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = sda_bus;  tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack_n);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic addr_chk(input string tag, input logic [7:0] a);
    logic ack_n;
    write_byte(a, ack_n);
    check(tag, {7'd0, ack_n}, (a[7:1] == 7'h41) ? 8'd0 : 8'd1);
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] v);
    logic ack_n;
    write_byte(v, ack_n);
    check(tag, {7'd0, ack_n}, 8'd0);
    model_write(v);
  endtask

  task automatic rd_chk(input string tag, input logic nack);
    logic [7:0] v;
    read_byte(nack, v);
    check(tag, v, model_read());
  endtask

  // LED n cycles after release: flash phase lagged by the output register.
  task automatic check_leds(input string tag, input int n);
    logic er;
    logic eg;
    for (int i = 0; i < n; i++) begin
      tick(1);
      er = (ncyc == 0) ? 1'b0 : 1'(((ncyc - 1) / DIV) % 2);
      eg = mode_m[0] ? er : ~er;
      check(tag, {6'd0, ledr, ledg}, {6'd0, er, eg});
    end
  endtask

  initial begin
    logic ack_n;
    logic [7:0] a;
    logic [7:0] v;
    int kind;
    int nb;

    model_reset();
    tick(3);
    check("rst_led", {6'd0, ledr, ledg}, 8'h01);
    check("rst_sda", {7'd0, sda_bus}, 8'h01);
    gsrn = 1'b1;
    check_leds("reset_flash", 12);
    check("idle_sda", {7'd0, sda_bus}, 8'h01);

    // Mode write: synchronous flashing.
    i2c_start();
    addr_chk("w_addr", 8'h82);
    wr_chk("w_ptr", 8'h02);
    wr_chk("w_mode", 8'h41);
    i2c_stop();
    check_leds("sync_flash", 10);

    // Wrong address is NACKed and changes nothing.
    i2c_start();
    addr_chk("bad_addr", 8'h84);
    i2c_stop();
    check_leds("after_nack", 6);

    // Write then repeated-start read with master NACK.
    i2c_start();
    addr_chk("wr_addr2", 8'h82);
    wr_chk("wr_ptr2", 8'h02);
    wr_chk("wr_mode2", 8'h41);
    i2c_start();
    addr_chk("rd_addr", 8'h83);
    rd_chk("rd_data", 1'b1);
    tick(4);
    check("rd_release", {7'd0, sda_bus}, 8'h01);
    i2c_stop();

    // Reserved command byte is ACKed and ignored.
    i2c_start();
    addr_chk("c5_addr", 8'h82);
    wr_chk("c5_ptr", 8'h02);
    wr_chk("c5_byte", 8'hC5);
    i2c_start();
    addr_chk("c5_rd_addr", 8'h83);
    rd_chk("c5_rd", 1'b1);
    i2c_stop();

    // Non-MODE pointer reads back zero payload.
    i2c_start();
    addr_chk("p5_addr", 8'h82);
    wr_chk("p5_ptr", 8'h05);
    i2c_start();
    addr_chk("p5_rd_addr", 8'h83);
    rd_chk("p5_rd", 1'b1);
    i2c_stop();

    // Reset pulse in the middle of the data byte of a MODE write.
    i2c_start();
    addr_chk("ab_addr", 8'h82);
    wr_chk("ab_ptr", 8'h02);
    fork
      write_byte(8'h40, ack_n);
      begin
        tick(3 * 4 * Q + 4);
        gsrn = 1'b0;
        model_reset();
        tick(1);
        check("ab_rst_led", {6'd0, ledr, ledg}, 8'h01);
        tick(2);
        gsrn = 1'b1;
      end
    join
    check("ab_ack", {7'd0, ack_n}, 8'h01);
    i2c_stop();
    check_leds("ab_leds", 8);
    i2c_start();
    addr_chk("ab2_addr", 8'h82);
    wr_chk("ab2_ptr", 8'h02);
    wr_chk("ab2_mode", 8'h41);
    i2c_stop();
    check_leds("ab2_leds", 8);

    // Randomized transactions.
    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        i2c_start();
        addr_chk("rw_addr", 8'h82);
        nb = $urandom_range(1, 3);
        for (int i = 0; i < nb; i++) begin
          case ($urandom_range(0, 3))
            0:       v = {2'b00, 6'($urandom_range(0, 3))};
            1:       v = {2'b01, 6'($urandom)};
            2:       v = 8'h02;
            default: v = 8'($urandom);
          endcase
          wr_chk("rw_byte", v);
        end
        i2c_stop();
      end else if (kind == 1) begin
        i2c_start();
        addr_chk("rr_addr", 8'h83);
        nb = $urandom_range(1, 2);
        for (int i = 0; i < nb; i++) rd_chk("rr_byte", (i == nb - 1));
        tick(4);
        check("rr_release", {7'd0, sda_bus}, 8'h01);
        i2c_stop();
      end else begin
        a = 8'($urandom);
        if (a[7:1] == 7'h41) a = a ^ 8'h10;
        i2c_start();
        addr_chk("rn_addr", a);
        i2c_stop();
      end
      check_leds("r_leds", 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
